matmul_engine: RTL and testbench
================================

MATMUL_ENGINE -- requirements
Module: matmul_engine

Interface
REQ-001 Parameter N, default 2, meaning matrix dimension (legal 2..4); sets the NxN systolic array size.
REQ-002 Parameter DW, default 8, meaning operand and output byte width; operands are signed two's complement.
REQ-003 Derived constant ACC_W = 2*DW + clog2(N), meaning accumulator width; no accumulator overflow is possible.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 in_valid  in  1  host byte valid.
REQ-007 in_ready  out  1  engine accepts a byte; a transfer occurs when in_valid and in_ready are both high at a clock edge.
REQ-008 in_data  in  DW  operand byte.
REQ-009 cfg_transpose  in  1  use W transposed.
REQ-010 cfg_relu  in  1  clamp negative results to 0.
REQ-011 cfg_sat  in  1  1 = saturate to signed DW; 0 = take the low DW bits.
REQ-012 abort  in  1  synchronous return to IDLE.
REQ-013 out_valid  out  1  result byte valid.
REQ-014 out_ready  in  1  host accepts the result byte.
REQ-015 out_data  out  DW  result byte.
REQ-016 out_last  out  1  high with the final result byte, C[N-1][N-1].
REQ-017 state_out  out  2  IDLE=0, LOAD=1, COMPUTE=2, OUTPUT=3.

Function
REQ-018 in_ready SHALL be high only in IDLE and LOAD.
REQ-019 A transfer in IDLE SHALL store the byte as W[0][0], latch cfg_transpose, cfg_relu and cfg_sat, and move to LOAD.
REQ-020 The load SHALL take exactly 2*N*N bytes: W row-major first, then X row-major; config changes after the latch SHALL have no effect.
REQ-021 The transfer of the last byte SHALL move the FSM to COMPUTE and clear all accumulators in the same edge.
REQ-022 The engine SHALL compute C[i][j] = sum over k of X[i][k]*W[k][j], using W[j][k] when transpose is latched, with full signed products and accumulation.
REQ-023 Operands SHALL be fed with a systolic skew: row i of X delayed i cycles, column j of W delayed j cycles.
REQ-024 COMPUTE SHALL last exactly 3N-1 cycles; out_valid SHALL rise in the first OUTPUT cycle.
REQ-025 Results SHALL be emitted row-major; each result is ReLU'd first if latched, then saturated to [-2^(DW-1), 2^(DW-1)-1] or truncated.
REQ-026 While out_valid is high and out_ready is low, out_data, out_last and out_valid SHALL hold stable.
REQ-027 The handshake with out_last high SHALL return the FSM to IDLE; in_ready SHALL be high in the next cycle.
REQ-028 In IDLE the engine SHALL hold out_valid low and out_data at 0.
REQ-029 abort high at any edge SHALL force IDLE, clear the load counter, the output index and all accumulators, and drop out_valid; abort overrides a simultaneous transfer.
REQ-030 In_valid asserted outside IDLE/LOAD SHALL be ignored with no state change.

Reset
REQ-031 On rst high, immediately and regardless of clock, the engine SHALL enter IDLE and clear the operand stores, accumulators, skew registers and counters.
REQ-032 Output values while rst is high: in_ready=0, out_valid=0, out_data=0, out_last=0, state_out=0.
REQ-033 in_ready SHALL rise on the first edge after rst deasserts.
REQ-034 Reset mid-LOAD, COMPUTE or OUTPUT SHALL discard all partial data.

Structure
REQ-035 Package matmul_pkg SHALL hold the state enum, the ACC_W function and the saturate/ReLU function.
REQ-036 The multiply-accumulate cell SHALL be the single sub-module matmul_pe, instantiated NxN times; it passes a east, b south, and accumulates with a clear input.

Verification
REQ-037 N=2, W=[[1,2],[3,4]], X=[[5,6],[7,8]], no config -> outputs 23,34,31,46; out_last on 46; out_valid exactly 3N-1=5 cycles after the last load edge.
REQ-038 Same operands with transpose=1 -> outputs 17,39,23,53.
REQ-039 W=identity, X=[[-3,4],[5,-6]], relu=1 -> outputs 0,4,5,0; with relu=0 -> 0xFD,4,5,0xFA.
REQ-040 All operands 127, N=2: sat=1 -> 127 x4; sat=0 -> 0x02 x4, since 32258=0x7E02.
REQ-041 Toggle out_ready randomly during OUTPUT -> data stable while stalled and ordering preserved; rst pulse mid-COMPUTE -> reset values per REQ-032, and the next full load yields the correct results.
REQ-042 abort raised at byte 5 of a load -> IDLE next cycle; a fresh full load then yields correct results; in_valid held during COMPUTE -> no effect.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
package matmul_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_COMPUTE = 2'd2,
    S_OUTPUT  = 2'd3
  } state_t;

  // Accumulator width: full signed product plus growth for N terms.
  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  // ReLU first (if enabled), then either clamp to signed dw or pass through
  // so the caller can keep the low dw bits.
  function automatic logic signed [31:0] post_proc(input logic signed [31:0] v,
                                                   input int dw,
                                                   input logic relu,
                                                   input logic sat);
    logic signed [31:0] t, mx, mn;
    t  = (relu && (v < 0)) ? 32'sd0 : v;
    mx = (32'sd1 <<< (dw - 1)) - 32'sd1;
    mn = -(32'sd1 <<< (dw - 1));
    if (sat) begin
      if (t > mx)      t = mx;
      else if (t < mn) t = mn;
    end
    return t;
  endfunction

endpackage

// File: rtl/matmul_if.sv
// Host-side byte stream in, result byte stream out, config and status.
interface matmul_if #(parameter int DW = 8);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          cfg_transpose;
  logic          cfg_relu;
  logic          cfg_sat;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [1:0]    state_out;

  modport master (
    output in_valid, in_data, cfg_transpose, cfg_relu, cfg_sat, abort, out_ready,
    input  in_ready, out_valid, out_data, out_last, state_out
  );

  modport slave (
    input  in_valid, in_data, cfg_transpose, cfg_relu, cfg_sat, abort, out_ready,
    output in_ready, out_valid, out_data, out_last, state_out
  );
endinterface

// File: rtl/matmul_pe.sv
// Systolic multiply-accumulate cell: a flows east, b flows south, one
// registered hop per cell; acc sums the signed products while enabled.
module matmul_pe #(
  parameter int DW    = 8,
  parameter int ACC_W = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [DW-1:0]           a_i,
  input  logic [DW-1:0]           b_i,
  output logic [DW-1:0]           a_o,
  output logic [DW-1:0]           b_o,
  output logic signed [ACC_W-1:0] acc_o
);
  logic [DW-1:0]           a_q, b_q;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [2*DW-1:0]  prod;

  // Full-width signed product and running sum.
  always_comb begin
    prod  = (2*DW)'(signed'(a_i)) * (2*DW)'(signed'(b_i));
    acc_d = acc_q + ACC_W'(prod);
  end

  // Pass-through registers and the accumulator; clear wins over enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q <= a_i;
      b_q <= b_i;
      if (clr_i)     acc_q <= '0;
      else if (en_i) acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;
endmodule

// File: rtl/matmul_engine.sv
// NxN systolic matrix-multiply engine: loads W then X as a byte stream,
// runs the array for 3N-1 cycles, then streams C = X*W (or X*W^T) row-major.
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 8
) (
  input logic     clk,
  input logic     rst,
  matmul_if.slave bus
);
  localparam int ACC_W = acc_width(N, DW);
  localparam int NN    = N * N;
  localparam int LW    = $clog2(2 * NN);
  localparam int CW    = $clog2(3 * N - 1);
  localparam int OW    = $clog2(NN);
  localparam logic [LW-1:0] LD_LAST  = LW'(2 * NN - 1);
  localparam logic [LW-1:0] LD_W     = LW'(NN);
  localparam logic [CW-1:0] CMP_LAST = CW'(3 * N - 2);
  localparam logic [OW-1:0] OUT_LAST = OW'(NN - 1);

  state_t                  state_q, state_d;
  logic [LW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [OW-1:0]           oidx_q, oidx_d;
  logic                    rdy_q;
  logic                    tr_q, relu_q, sat_q;
  logic [NN-1:0][DW-1:0]   w_q, x_q;
  logic [N-1:0][DW-1:0]    a_feed, b_feed, a_skew_q, b_skew_q;
  logic [N-1:0][N-1:0][DW-1:0] a_w, b_w;
  logic signed [ACC_W-1:0] acc_w [NN];
  logic signed [ACC_W-1:0] acc_sel;
  logic                    xfer, clr_acc, out_vld;

  // rdy_q keeps in_ready low until the first edge after reset releases.
  assign bus.in_ready = rdy_q && ((state_q == S_IDLE) || (state_q == S_LOAD));
  assign xfer         = bus.in_valid && bus.in_ready;

  // State, counters and the ready-enable flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cyc_q   <= '0;
      oidx_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      oidx_q  <= oidx_d;
      rdy_q   <= 1'b1;
    end
  end

  // Next state; abort beats everything including a same-edge transfer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    oidx_d  = oidx_q;
    clr_acc = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      cyc_d   = '0;
      oidx_d  = '0;
      clr_acc = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: if (xfer) begin
          state_d = S_LOAD;
          cnt_d   = LW'(1);
        end
        S_LOAD: if (xfer) begin
          if (cnt_q == LD_LAST) begin
            state_d = S_COMPUTE;
            cnt_d   = '0;
            cyc_d   = '0;
            clr_acc = 1'b1;
          end else begin
            cnt_d = cnt_q + LW'(1);
          end
        end
        S_COMPUTE: begin
          if (cyc_q == CMP_LAST) begin
            state_d = S_OUTPUT;
            cyc_d   = '0;
            oidx_d  = '0;
          end else begin
            cyc_d = cyc_q + CW'(1);
          end
        end
        S_OUTPUT: if (bus.out_ready) begin
          if (oidx_q == OUT_LAST) begin
            state_d = S_IDLE;
            oidx_d  = '0;
          end else begin
            oidx_d = oidx_q + OW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Operand stores and config latch; config is captured with the first byte only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q    <= '0;
      x_q    <= '0;
      tr_q   <= 1'b0;
      relu_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (xfer && !bus.abort) begin
      if (state_q == S_IDLE) begin
        w_q[0] <= bus.in_data;
        tr_q   <= bus.cfg_transpose;
        relu_q <= bus.cfg_relu;
        sat_q  <= bus.cfg_sat;
      end else if (cnt_q < LD_W) begin
        w_q[OW'(cnt_q)] <= bus.in_data;
      end else begin
        x_q[OW'(cnt_q - LD_W)] <= bus.in_data;
      end
    end
  end

  // Skewed feed: row i of X and column i of W start i cycles late.
  always_comb begin
    a_feed = '0;
    b_feed = '0;
    if (state_q == S_COMPUTE) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (cyc_q == CW'(i + k)) begin
            a_feed[i] = x_q[i*N + k];
            b_feed[i] = tr_q ? w_q[i*N + k] : w_q[k*N + i];
          end
        end
      end
    end
  end

  // Skew registers at the array edge; this hop makes COMPUTE 3N-1 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_skew_q <= '0;
      b_skew_q <= '0;
    end else begin
      a_skew_q <= a_feed;
      b_skew_q <= b_feed;
    end
  end

  for (genvar e = 0; e < N; e++) begin : g_edge
    assign a_w[e][0] = a_skew_q[e];
    assign b_w[0][e] = b_skew_q[e];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] a_nx, b_nx;

      matmul_pe #(.DW(DW), .ACC_W(ACC_W)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clr_acc),
        .en_i  (state_q == S_COMPUTE),
        .a_i   (a_w[i][j]),
        .b_i   (b_w[i][j]),
        .a_o   (a_nx),
        .b_o   (b_nx),
        .acc_o (acc_w[i*N + j])
      );

      if (j < N - 1) begin : g_east
        assign a_w[i][j+1] = a_nx;
      end else begin : g_east_end
        logic [DW-1:0] east_unused;
        assign east_unused = a_nx;
      end

      if (i < N - 1) begin : g_south
        assign b_w[i+1][j] = b_nx;
      end else begin : g_south_end
        logic [DW-1:0] south_unused;
        assign south_unused = b_nx;
      end
    end
  end

  // Result stream straight off the held accumulators, so a stall keeps it stable.
  assign out_vld       = (state_q == S_OUTPUT);
  assign acc_sel       = acc_w[oidx_q];
  assign bus.out_valid = out_vld;
  assign bus.out_last  = out_vld && (oidx_q == OUT_LAST);
  assign bus.out_data  = out_vld ? DW'(post_proc(32'(acc_sel), DW, relu_q, sat_q)) : '0;
  assign bus.state_out = state_q;
endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine at N=2, DW=8.
module tb_matmul_engine;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         total = 0;
  int         bad   = 0;
  logic [7:0] vec  [8];
  logic [7:0] eexp [4];

  matmul_if #(.DW(8)) bus ();

  matmul_engine #(.N(2), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Sends vec[0..n-1]; config is inverted after the first byte to show it is latched.
  task automatic load(input int n, input logic tr, input logic relu, input logic sat);
    for (int k = 0; k < n; k++) begin
      bus.in_valid      = 1'b1;
      bus.in_data       = vec[k];
      bus.cfg_transpose = (k == 0) ? tr   : ~tr;
      bus.cfg_relu      = (k == 0) ? relu : ~relu;
      bus.cfg_sat       = (k == 0) ? sat  : ~sat;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Counts edges from the last load edge to out_valid; optionally keeps in_valid up.
  task automatic wait_out(input bit junk);
    int c;
    c = 0;
    if (junk) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA5;
    end
    while (bus.out_valid !== 1'b1 && c < 50) begin
      @(posedge clk); #1;
      c++;
      if (junk && c == 2) chk("hold_state", 32'(bus.state_out), 2);
    end
    bus.in_valid = 1'b0;
    chk("latency", c, 5);
  endtask

  task automatic collect(input bit stall);
    for (int idx = 0; idx < 4; idx++) begin
      if (stall && (idx % 2 == 0)) begin
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_valid", 32'(bus.out_valid), 1);
        chk("stall_data", 32'(bus.out_data), 32'(eexp[idx]));
        chk("stall_last", 32'(bus.out_last), (idx == 3) ? 1 : 0);
      end
      bus.out_ready = 1'b1;
      chk("valid", 32'(bus.out_valid), 1);
      chk("data", 32'(bus.out_data), 32'(eexp[idx]));
      chk("last", 32'(bus.out_last), (idx == 3) ? 1 : 0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    chk("idle_valid", 32'(bus.out_valid), 0);
    chk("idle_data", 32'(bus.out_data), 0);
    chk("idle_ready", 32'(bus.in_ready), 1);
    chk("idle_state", 32'(bus.state_out), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", 32'(bus.in_ready), 0);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_data", 32'(bus.out_data), 0);
    chk("rst_last", 32'(bus.out_last), 0);
    chk("rst_state", 32'(bus.state_out), 0);
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.cfg_transpose = 1'b0;
    bus.cfg_relu      = 1'b0;
    bus.cfg_sat       = 1'b0;
    bus.abort         = 1'b0;
    bus.out_ready     = 1'b0;

    // Power-on reset and ready release
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_pre", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("ready_post", 32'(bus.in_ready), 1);

    // Plain product, stalled output
    vec  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load(8, 1'b0, 1'b0, 1'b0);
    chk("compute_state", 32'(bus.state_out), 2);
    chk("compute_ready", 32'(bus.in_ready), 0);
    eexp = '{8'd23, 8'd34, 8'd31, 8'd46};
    wait_out(1'b0);
    collect(1'b1);

    // Transposed W
    load(8, 1'b1, 1'b0, 1'b0);
    eexp = '{8'd17, 8'd39, 8'd23, 8'd53};
    wait_out(1'b0);
    collect(1'b0);

    // Identity W, negative X, with and without ReLU; in_valid held during compute
    vec  = '{8'd1, 8'd0, 8'd0, 8'd1, 8'hFD, 8'd4, 8'd5, 8'hFA};
    load(8, 1'b0, 1'b1, 1'b0);
    eexp = '{8'd0, 8'd4, 8'd5, 8'd0};
    wait_out(1'b1);
    collect(1'b0);
    load(8, 1'b0, 1'b0, 1'b0);
    eexp = '{8'hFD, 8'd4, 8'd5, 8'hFA};
    wait_out(1'b0);
    collect(1'b1);

    // Overflow of DW: saturate vs truncate (32258 = 0x7E02)
    vec  = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127};
    load(8, 1'b0, 1'b0, 1'b1);
    eexp = '{8'd127, 8'd127, 8'd127, 8'd127};
    wait_out(1'b0);
    collect(1'b0);
    load(8, 1'b0, 1'b0, 1'b0);
    eexp = '{8'h02, 8'h02, 8'h02, 8'h02};
    wait_out(1'b0);
    collect(1'b0);

    // Asynchronous reset in the middle of COMPUTE, then a clean run
    vec = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load(8, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_pre2", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    chk("ready_post2", 32'(bus.in_ready), 1);
    load(8, 1'b0, 1'b0, 1'b0);
    eexp = '{8'd23, 8'd34, 8'd31, 8'd46};
    wait_out(1'b0);
    collect(1'b0);

    // Abort on the sixth byte overrides the transfer; then a fresh load
    load(5, 1'b1, 1'b0, 1'b0);
    chk("abort_pre_state", 32'(bus.state_out), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = vec[5];
    bus.abort    = 1'b1;
    @(posedge clk); #1;
    chk("abort_state", 32'(bus.state_out), 0);
    chk("abort_valid", 32'(bus.out_valid), 0);
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    chk("abort_ready", 32'(bus.in_ready), 1);
    load(8, 1'b1, 1'b0, 1'b0);
    eexp = '{8'd17, 8'd39, 8'd23, 8'd53};
    wait_out(1'b1);
    collect(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
